// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU controller.
// Holds the ALU function codes, the operand/result widths and the FSM state encoding.
// The ALU itself lives at the datapath level; only its interface widths are fixed here.
package alu_arbiter_pkg;

  localparam int WORD   = 16;
  localparam int FUNC_W = 3;

  // ALU function codes (forwarded untouched, the ALU interprets them)
  localparam logic [FUNC_W-1:0] FUNC_ADD = 3'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 3'd1;
  localparam logic [FUNC_W-1:0] FUNC_AND = 3'd2;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 3'd3;
  localparam logic [FUNC_W-1:0] FUNC_XOR = 3'd4;
  localparam logic [FUNC_W-1:0] FUNC_SHL = 3'd5;
  localparam logic [FUNC_W-1:0] FUNC_SHR = 3'd6;
  localparam logic [FUNC_W-1:0] FUNC_TCP = 3'd7;

  typedef enum logic [1:0] {
    ALU_ARB_IDLE = 2'd0,
    ALU_ARB_EXEC = 2'd1,
    ALU_ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request/response handshakes for both requesters plus the ALU operand/result bus.
// slave modport is the controller's view; master modport is the requester/ALU side.
// Purely wiring, no latency.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [WORD-1:0]   req0_a;
  logic [WORD-1:0]   req0_b;
  logic [FUNC_W-1:0] req0_func;
  logic              resp0_valid;
  logic              resp0_ready;
  logic [WORD-1:0]   resp0_c;
  logic              resp0_ovf;

  logic              req1_valid;
  logic              req1_ready;
  logic [WORD-1:0]   req1_a;
  logic [WORD-1:0]   req1_b;
  logic [FUNC_W-1:0] req1_func;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [WORD-1:0]   resp1_c;
  logic              resp1_ovf;

  logic [WORD-1:0]   alu_a;
  logic [WORD-1:0]   alu_b;
  logic [FUNC_W-1:0] alu_func;
  logic [WORD-1:0]   alu_c;
  logic              alu_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_func, resp1_ready,
    input  alu_c, alu_ovf,
    output req0_ready, resp0_valid, resp0_c, resp0_ovf,
    output req1_ready, resp1_valid, resp1_c, resp1_ovf,
    output alu_a, alu_b, alu_func
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_func, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_func, resp1_ready,
    output alu_c, alu_ovf,
    input  req0_ready, resp0_valid, resp0_c, resp0_ovf,
    input  req1_ready, resp1_valid, resp1_c, resp1_ovf,
    input  alu_a, alu_b, alu_func
  );

endinterface

// File: rtl/alu_arb_pick.sv
// Grant selection between the two requesters (combinational, zero latency).
// Default: round-robin, contention goes to the requester that did not win last.
// ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention, last_grant ignored.
module alu_arb_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: requester 1 only wins when requester 0 is absent
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = ~valid0;
  end
`else
  // Round-robin: sole requester wins, contention flips away from last winner
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = ~valid0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Controller for the shared combinational ALU: arbitrates two requesters, registers operands, returns results.
// Latency: handshake at cycle N -> response valid at N+2; one op in flight, 3 cycles per op minimum.
// Backpressure: request ready only in IDLE; response held stable until the owner raises resp ready.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (requester 0 wins all contention).
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [WORD-1:0]   a_q, a_d;
  logic [WORD-1:0]   b_q, b_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [WORD-1:0]   resp0_c_q, resp0_c_d;
  logic              resp0_ovf_q, resp0_ovf_d;
  logic [WORD-1:0]   resp1_c_q, resp1_c_d;
  logic              resp1_ovf_q, resp1_ovf_d;

  logic grant_valid;
  logic grant_id;

  alu_arb_pick u_pick (
    .valid0      (bus.req0_valid),
    .valid1      (bus.req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // ALU operands come straight from the operand registers, so they only move on a new handshake
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_func  = func_q;
  assign bus.resp0_c   = resp0_c_q;
  assign bus.resp0_ovf = resp0_ovf_q;
  assign bus.resp1_c   = resp1_c_q;
  assign bus.resp1_ovf = resp1_ovf_q;

  // Next-state, register loads and handshake outputs
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    a_d            = a_q;
    b_d            = b_q;
    func_d         = func_q;
    resp0_c_d      = resp0_c_q;
    resp0_ovf_d    = resp0_ovf_q;
    resp1_c_d      = resp1_c_q;
    resp1_ovf_d    = resp1_ovf_q;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;

    case (state_q)
      ALU_ARB_IDLE: begin
        // Ready follows the grant, so a grant is always a handshake
        if (grant_valid) begin
          bus.req0_ready = ~grant_id;
          bus.req1_ready = grant_id;
          owner_d        = grant_id;
          last_grant_d   = grant_id;
          a_d            = grant_id ? bus.req1_a    : bus.req0_a;
          b_d            = grant_id ? bus.req1_b    : bus.req0_b;
          func_d         = grant_id ? bus.req1_func : bus.req0_func;
          state_d        = ALU_ARB_EXEC;
        end
      end
      ALU_ARB_EXEC: begin
        // ALU has had a full cycle on registered operands; capture into the owner's result slot
        if (owner_q) begin
          resp1_c_d   = bus.alu_c;
          resp1_ovf_d = bus.alu_ovf;
        end else begin
          resp0_c_d   = bus.alu_c;
          resp0_ovf_d = bus.alu_ovf;
        end
        state_d = ALU_ARB_RESP;
      end
      ALU_ARB_RESP: begin
        bus.resp0_valid = ~owner_q;
        bus.resp1_valid = owner_q;
        if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
          state_d = ALU_ARB_IDLE;
        end
      end
      default: begin
        state_d = ALU_ARB_IDLE;
      end
    endcase
  end

  // State and data registers; reset leaves requester 0 favoured on first contention
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ALU_ARB_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      func_q       <= '0;
      resp0_c_q    <= '0;
      resp0_ovf_q  <= 1'b0;
      resp1_c_q    <= '0;
      resp1_ovf_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      func_q       <= func_d;
      resp0_c_q    <= resp0_c_d;
      resp0_ovf_q  <= resp0_ovf_d;
      resp1_c_q    <= resp1_c_d;
      resp1_ovf_q  <= resp1_ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the operand bus.
// Each scenario task drives its own vectors and compares against hand-computed values.
// Expectations for contention follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: ovf only meaningful for ADD/SUB
  logic [WORD-1:0] add_r, sub_r;
  assign add_r = bus.alu_a + bus.alu_b;
  assign sub_r = bus.alu_a - bus.alu_b;

  always_comb begin
    bus.alu_c   = '0;
    bus.alu_ovf = 1'b0;
    case (bus.alu_func)
      FUNC_ADD: begin
        bus.alu_c   = add_r;
        bus.alu_ovf = (bus.alu_a[15] == bus.alu_b[15]) && (add_r[15] != bus.alu_a[15]);
      end
      FUNC_SUB: begin
        bus.alu_c   = sub_r;
        bus.alu_ovf = (bus.alu_a[15] != bus.alu_b[15]) && (sub_r[15] != bus.alu_a[15]);
      end
      FUNC_AND: bus.alu_c = bus.alu_a & bus.alu_b;
      FUNC_OR:  bus.alu_c = bus.alu_a | bus.alu_b;
      FUNC_XOR: bus.alu_c = bus.alu_a ^ bus.alu_b;
      FUNC_SHL: bus.alu_c = bus.alu_a << 1;
      FUNC_SHR: bus.alu_c = bus.alu_a >> 1;
      default:  bus.alu_c = (~bus.alu_a) + 16'd1;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_func = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_func = '0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if ({bus.alu_a, bus.alu_b, bus.alu_func} !== 35'd0) $display("FAIL reset_alu got=%h exp=0", {bus.alu_a, bus.alu_b, bus.alu_func}); else passed++;
    total++; if ({bus.resp0_c, bus.resp0_ovf, bus.resp1_c, bus.resp1_ovf} !== 34'd0) $display("FAIL reset_resp_data got=%h exp=0", {bus.resp0_c, bus.resp0_ovf, bus.resp1_c, bus.resp1_ovf}); else passed++;
    total++; if ({bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready} !== 4'b0) $display("FAIL reset_hs got=%b exp=0000", {bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.req1_ready}); else passed++;
  endtask

  task automatic test_overflow_add;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h7FFF; bus.req0_b = 16'h0001; bus.req0_func = FUNC_ADD;
    #1;
    total++; if (bus.req0_ready !== 1'b1) $display("FAIL add_req0_ready got=%b exp=1", bus.req0_ready); else passed++;
    tick();
    bus.req0_valid = 1'b0;
    total++; if (bus.alu_a !== 16'h7FFF || bus.alu_func !== FUNC_ADD) $display("FAIL add_exec_alu got=%h/%0d exp=7fff/0", bus.alu_a, bus.alu_func); else passed++;
    total++; if (bus.resp0_valid !== 1'b0) $display("FAIL add_resp_early got=%b exp=0", bus.resp0_valid); else passed++;
    tick();
    total++; if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0) $display("FAIL add_resp_valid got=%b%b exp=10", bus.resp0_valid, bus.resp1_valid); else passed++;
    total++; if (bus.resp0_c !== 16'h8000 || bus.resp0_ovf !== 1'b1) $display("FAIL add_result got=%h ovf=%b exp=8000 ovf=1", bus.resp0_c, bus.resp0_ovf); else passed++;
    bus.resp0_ready = 1'b1;
    tick();
    bus.resp0_ready = 1'b0;
    total++; if (bus.resp0_valid !== 1'b0 || bus.resp0_c !== 16'h8000) $display("FAIL add_after_ack got=%b/%h exp=0/8000", bus.resp0_valid, bus.resp0_c); else passed++;
  endtask

  task automatic test_contention;
    int g0, g1, ops, prev, repeats;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 16'd3;  bus.req0_b = 16'd4; bus.req0_func = FUNC_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 16'd10; bus.req1_b = 16'd3; bus.req1_func = FUNC_SUB;
    #1;
    total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL cont_first_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); else passed++;
    tick();
    bus.req0_valid = 1'b0;
    #1;
    total++; if (bus.req1_ready !== 1'b0) $display("FAIL cont_ready_busy got=%b exp=0", bus.req1_ready); else passed++;
    tick();
    total++; if (bus.resp0_valid !== 1'b1 || bus.resp0_c !== 16'd7 || bus.resp1_valid !== 1'b0) $display("FAIL cont_resp0 got=%b/%h/%b exp=1/0007/0", bus.resp0_valid, bus.resp0_c, bus.resp1_valid); else passed++;
    bus.resp0_ready = 1'b1;
    tick();
    bus.resp0_ready = 1'b0;
    #1;
    total++; if (bus.req1_ready !== 1'b1) $display("FAIL cont_req1_ready got=%b exp=1", bus.req1_ready); else passed++;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    total++; if (bus.resp1_valid !== 1'b1 || bus.resp1_c !== 16'd7 || bus.resp1_ovf !== 1'b0) $display("FAIL cont_resp1 got=%b/%h/%b exp=1/0007/0", bus.resp1_valid, bus.resp1_c, bus.resp1_ovf); else passed++;
    bus.resp1_ready = 1'b1;
    tick();
    bus.resp1_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL cont_alternate got=%b exp=10", {bus.req0_ready, bus.req1_ready}); else passed++;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    g0 = 0; g1 = 0; ops = 0; prev = -1; repeats = 0;
    for (int cyc = 0; cyc < 60 && ops < 10; cyc++) begin
      if (bus.req0_ready) begin g0++; ops++; if (prev == 0) repeats++; prev = 0; end
      if (bus.req1_ready) begin g1++; ops++; if (prev == 1) repeats++; prev = 1; end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    total++; if (ops !== 10) $display("FAIL cont_ops_timeout got=%0d exp=10", ops); else passed++;
`ifdef ALU_ARB_FIXED_PRIO_EN
    total++; if (g1 !== 0) $display("FAIL cont_fixed_g1 got=%0d exp=0", g1); else passed++;
`else
    total++; if (g0 !== 5 || g1 !== 5 || repeats !== 0) $display("FAIL cont_fair got=%0d/%0d rep=%0d exp=5/5 rep=0", g0, g1, repeats); else passed++;
`endif
    tick(); tick(); tick();
    idle_inputs();
  endtask

  task automatic test_resp_hold;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h4001; bus.req1_b = 16'h0000; bus.req1_func = FUNC_SHL;
    #1;
    total++; if (bus.req1_ready !== 1'b1) $display("FAIL hold_req1_ready got=%b exp=1", bus.req1_ready); else passed++;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_func = FUNC_ADD;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.resp1_valid !== 1'b1 || bus.resp1_c !== 16'h8002) $display("FAIL hold_resp1 cyc=%0d got=%b/%h exp=1/8002", i, bus.resp1_valid, bus.resp1_c); else passed++;
      total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) $display("FAIL hold_readies cyc=%0d got=%b exp=00", i, {bus.req0_ready, bus.req1_ready}); else passed++;
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp1_ready = 1'b1;
    tick();
    bus.resp1_ready = 1'b0;
    #1;
    total++; if (bus.resp1_valid !== 1'b0 || bus.resp1_c !== 16'h8002) $display("FAIL hold_after_ack got=%b/%h exp=0/8002", bus.resp1_valid, bus.resp1_c); else passed++;
  endtask

  task automatic test_reset_mid_exec;
    logic seen;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h0005; bus.req0_b = 16'h0000; bus.req0_func = FUNC_TCP;
    tick();
    bus.req0_valid = 1'b0;
    total++; if (bus.alu_a !== 16'h0005 || bus.alu_func !== FUNC_TCP) $display("FAIL rst_exec_alu got=%h/%0d exp=0005/7", bus.alu_a, bus.alu_func); else passed++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if ({bus.alu_a, bus.alu_b, bus.alu_func} !== 35'd0) $display("FAIL rst_mid_alu got=%h exp=0", {bus.alu_a, bus.alu_b, bus.alu_func}); else passed++;
    total++; if ({bus.resp0_c, bus.resp0_ovf, bus.resp1_c, bus.resp1_ovf} !== 34'd0) $display("FAIL rst_mid_resp_data got=%h exp=0", {bus.resp0_c, bus.resp0_ovf, bus.resp1_c, bus.resp1_ovf}); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | bus.resp0_valid | bus.resp1_valid;
      tick();
    end
    total++; if (seen !== 1'b0) $display("FAIL rst_mid_no_resp got=%b exp=0", seen); else passed++;
  endtask

  task automatic test_contention_four;
    logic [0:3] seq;
    logic [0:3] exp_seq;
    int ops;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_seq = 4'b0000;
`else
    exp_seq = 4'b0101;
`endif
    seq = '1;
    ops = 0;
    bus.req0_valid = 1'b1; bus.req0_func = FUNC_AND;
    bus.req1_valid = 1'b1; bus.req1_func = FUNC_OR;
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 30 && ops < 4; cyc++) begin
      if (bus.req0_ready || bus.req1_ready) begin
        seq[ops] = bus.req1_ready;
        ops++;
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    total++; if (ops !== 4) $display("FAIL four_ops_timeout got=%0d exp=4", ops); else passed++;
    total++; if (seq !== exp_seq) $display("FAIL four_order got=%b exp=%b", seq, exp_seq); else passed++;
    tick(); tick(); tick();
    idle_inputs();
  endtask

  task automatic test_pulse_while_busy;
    int extra;
    bus.req0_valid = 1'b1; bus.req0_a = 16'hF0F0; bus.req0_b = 16'h0FF0; bus.req0_func = FUNC_XOR;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h1111; bus.req0_b = 16'h1111; bus.req0_func = FUNC_ADD;
    #1;
    total++; if (bus.req0_ready !== 1'b0) $display("FAIL pulse_ready got=%b exp=0", bus.req0_ready); else passed++;
    tick();
    bus.req0_valid = 1'b0;
    total++; if (bus.resp0_valid !== 1'b1 || bus.resp0_c !== 16'hFF00) $display("FAIL pulse_orig got=%b/%h exp=1/ff00", bus.resp0_valid, bus.resp0_c); else passed++;
    bus.resp0_ready = 1'b1;
    tick();
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp0_valid) extra++;
      tick();
    end
    bus.resp0_ready = 1'b0;
    total++; if (extra !== 0 || bus.alu_a !== 16'hF0F0) $display("FAIL pulse_no_extra got=%0d/%h exp=0/f0f0", extra, bus.alu_a); else passed++;
  endtask

  task automatic test_func_forward;
    logic [WORD-1:0] exp_c [8];
    exp_c[0] = 16'h2143; exp_c[1] = 16'h0325; exp_c[2] = 16'h0204; exp_c[3] = 16'h1F3F;
    exp_c[4] = 16'h1D3B; exp_c[5] = 16'h2468; exp_c[6] = 16'h091A; exp_c[7] = 16'hEDCC;
    for (int f = 0; f < 8; f++) begin
      bus.req1_valid = 1'b1; bus.req1_a = 16'h1234; bus.req1_b = 16'h0F0F; bus.req1_func = f[2:0];
      tick();
      bus.req1_valid = 1'b0;
      total++; if (bus.alu_func !== f[2:0]) $display("FAIL func_fwd f=%0d got=%0d exp=%0d", f, bus.alu_func, f); else passed++;
      tick();
      total++; if (bus.resp1_valid !== 1'b1 || bus.resp1_c !== exp_c[f] || bus.resp1_ovf !== 1'b0) $display("FAIL func_result f=%0d got=%b/%h/%b exp=1/%h/0", f, bus.resp1_valid, bus.resp1_c, bus.resp1_ovf, exp_c[f]); else passed++;
      bus.resp1_ready = 1'b1;
      tick();
      bus.resp1_ready = 1'b0;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_overflow_add();
    test_contention();
    test_resp_hold();
    test_reset_mid_exec();
    test_contention_four();
    test_pulse_while_busy();
    test_func_forward();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
